accum_xcel_sched: RTL and testbench
===================================

ACCUM_XCEL_SCHED -- requirements
Module: AccumXcelSched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, job-queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, max RUN cycles before a job is aborted (1..65535).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port job_val  input  1  job request valid.
REQ-006 The block SHALL have port job_size  input  14  element count of requested job.
REQ-007 The block SHALL have port job_rdy  output  1  queue can accept a job this cycle.
REQ-008 The block SHALL have port xcel_go  output  1  go to accumulator accelerator.
REQ-009 The block SHALL have port xcel_size  output  14  size to accumulator accelerator.
REQ-010 The block SHALL have port xcel_result_val  input  1  accelerator result valid (level).
REQ-011 The block SHALL have port xcel_result  input  32  accelerator result.
REQ-012 The block SHALL have port done_val  output  1  one-cycle pulse: job completed.
REQ-013 The block SHALL have port done_result  output  32  result of last completed job.
REQ-014 The block SHALL have port done_cycles  output  16  RUN cycle count of last completed job.
REQ-015 The block SHALL have port total  output  32  running sum of all completed results.
REQ-016 The block SHALL have port jobs_done  output  8  count of completed jobs.
REQ-017 The block SHALL have port busy  output  1  1 when state != IDLE or queue non-empty.
REQ-018 The block SHALL have port err  output  1  sticky timeout flag.

Function
REQ-019 Queue: FIFO of DEPTH 14-bit sizes; enqueue when job_val && job_rdy; job_rdy = !full, independent of same-cycle dequeue.
REQ-020 job_val while full SHALL be ignored, no state change, no overwrite.
REQ-021 FSM states IDLE, RUN, DRAIN; IDLE->RUN when queue non-empty and xcel_result_val==0, popping head into size register.
REQ-022 Job enqueued into empty queue SHALL NOT dispatch same cycle; earliest RUN is the following cycle.
REQ-023 In RUN: xcel_go=1, xcel_size=size register, both stable for entire RUN; in IDLE/DRAIN xcel_go=0; xcel_size holds last dispatched value.
REQ-024 RUN cycle counter SHALL reset to 1 on entry to RUN, increment each RUN cycle, saturate at 16'hFFFF.
REQ-025 In RUN, xcel_result_val==1 SHALL, same edge: latch done_result=xcel_result, done_cycles=counter, total+=xcel_result (mod 2^32), jobs_done+=1 (mod 256), pulse done_val next cycle for exactly one cycle, go to DRAIN.
REQ-026 In RUN, counter reaching TIMEOUT without result_val SHALL set err=1, go to DRAIN, no done_val, no update to done_*/total/jobs_done.
REQ-027 DRAIN->IDLE when xcel_result_val==0; stays in DRAIN while it is 1.
REQ-028 Minimum gap between jobs: xcel_go SHALL be 0 for at least two cycles (DRAIN, IDLE).
REQ-029 Size 0 jobs SHALL be dispatched like any other.
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 rst==0 at a rising edge SHALL force: state IDLE, queue empty, xcel_go=0, xcel_size=0, done_val=0, done_result=0, done_cycles=0, total=0, jobs_done=0, err=0, busy=0, job_rdy=0 during reset.
REQ-032 Reset mid-RUN SHALL abandon the job and flush the queue; first cycle after release job_rdy=1, xcel_go=0.

Verification
REQ-033 Single job size=5, model returns 0x0F after 7 RUN cycles -> done_val one pulse, done_result=0x0F, done_cycles=7, total=0x0F, jobs_done=1.
REQ-034 Enqueue 5 jobs back-to-back, DEPTH=4, idle xcel -> first 4 accepted, job_rdy=0 on 5th with it dropped after 1 dispatch frees slot only if re-presented; order of xcel_size matches enqueue order.
REQ-035 Results 0xFFFFFFFF then 0x2 -> total=0x1, jobs_done=2.
REQ-036 TIMEOUT=10, model never asserts result_val -> xcel_go high exactly 10 cycles, err=1, no done_val, next queued job dispatches afterward.
REQ-037 result_val held high 3 cycles after capture -> stays in DRAIN 3 cycles, no dispatch until it falls, only one done_val.
REQ-038 rst=0 during RUN with 2 queued jobs -> all outputs reset values next cycle, no dispatch after release until new job enqueued.

Source files
------------

// File: rtl/accum_xcel_sched_if.sv
// accum_xcel_sched_if: job-request, accelerator and status signals of the accumulator scheduler
interface accum_xcel_sched_if;
   logic        job_val;
   logic [13:0] job_size;
   logic        job_rdy;
   logic        xcel_go;
   logic [13:0] xcel_size;
   logic        xcel_result_val;
   logic [31:0] xcel_result;
   logic        done_val;
   logic [31:0] done_result;
   logic [15:0] done_cycles;
   logic [31:0] total;
   logic [7:0]  jobs_done;
   logic        busy;
   logic        err;
   modport master (
      output job_val, job_size, xcel_result_val, xcel_result,
      input  job_rdy, xcel_go, xcel_size, done_val, done_result, done_cycles, total, jobs_done, busy, err
   );
   modport slave (
      input  job_val, job_size, xcel_result_val, xcel_result,
      output job_rdy, xcel_go, xcel_size, done_val, done_result, done_cycles, total, jobs_done, busy, err
   );
endinterface

// File: rtl/accum_xcel_sched.sv
// accum_xcel_sched: queues job sizes and dispatches them one at a time to an accumulator accelerator
module accum_xcel_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000
) (
   input logic               clk,
   input logic               rst,
   accum_xcel_sched_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t      r_state, w_next;
   logic [13:0] r_q [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0] r_cnt;
   logic [13:0] r_size;
   logic [15:0] r_cyc, r_dcyc;
   logic [31:0] r_res, r_tot;
   logic [7:0]  r_jobs;
   logic        r_done, r_err;
   logic        w_full, w_push, w_pop, w_cap, w_tmo;
   assign w_full          = r_cnt == (AW+1)'(DEPTH);
   assign w_push          = bus.job_val && bus.job_rdy;
   assign bus.job_rdy     = rst && !w_full;
   assign bus.xcel_go     = r_state == RUN;
   assign bus.xcel_size   = r_size;
   assign bus.done_val    = r_done;
   assign bus.done_result = r_res;
   assign bus.done_cycles = r_dcyc;
   assign bus.total       = r_tot;
   assign bus.jobs_done   = r_jobs;
   assign bus.busy        = r_state != IDLE || r_cnt != '0;
   assign bus.err         = r_err;
   // state register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end
   // dispatch only from a settled accelerator; a result beats a same-cycle timeout
   always_comb begin
      w_pop  = r_state == IDLE && r_cnt != '0 && !bus.xcel_result_val;
      w_cap  = r_state == RUN && bus.xcel_result_val;
      w_tmo  = r_state == RUN && !bus.xcel_result_val && r_cyc == 16'(TIMEOUT);
      w_next = r_state;
      if (w_pop) w_next = RUN;
      if (w_cap || w_tmo) w_next = DRAIN;
      if (r_state == DRAIN && !bus.xcel_result_val) w_next = IDLE;
   end
   // job FIFO; fullness alone gates acceptance so a same-cycle pop never frees a slot early
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_q[r_wp] <= bus.job_size;
            r_wp      <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // active job size, run-cycle counter, completion capture and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_size <= '0;
         r_cyc  <= '0;
         r_done <= 1'b0;
         r_res  <= '0;
         r_dcyc <= '0;
         r_tot  <= '0;
         r_jobs <= '0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_cap;
         if (w_pop) begin
            r_size <= r_q[r_rp];
            r_cyc  <= 16'd1;
         end else if (r_state == RUN) begin
            r_cyc <= (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;
         end
         if (w_cap) begin
            r_res  <= bus.xcel_result;
            r_dcyc <= r_cyc;
            r_tot  <= r_tot + bus.xcel_result;
            r_jobs <= r_jobs + 8'd1;
         end
         if (w_tmo) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_accum_xcel_sched.sv
// tb_accum_xcel_sched: directed vectors and corner-case sequences for accum_xcel_sched
module tb_accum_xcel_sched;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;
   accum_xcel_sched_if bus();
   accum_xcel_sched #(.DEPTH(4), .TIMEOUT(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic [13:0] size;
      logic [31:0] res;
      int          lat;
      logic [31:0] tot;
      logic [7:0]  jobs;
   } vec_t;
   vec_t tbl [4];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b0;
      bus.job_val = 1'b0;
      bus.xcel_result_val = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask
   task automatic enq(input logic [13:0] sz);
      for (int t = 0; t < 20 && !bus.job_rdy; t++) step();
      chk("enq_rdy", bus.job_rdy, 1);
      bus.job_val = 1'b1;
      bus.job_size = sz;
      step();
      bus.job_val = 1'b0;
   endtask
   task automatic do_run(input logic [13:0] sz, input logic [31:0] res, input int lat,
                         input logic [31:0] tot, input logic [7:0] jobs);
      logic ok;
      for (int t = 0; t < 20 && !bus.xcel_go; t++) step();
      chk("dispatch", bus.xcel_go, 1);
      chk("xcel_size", bus.xcel_size, sz);
      ok = 1'b1;
      for (int n = 1; n <= lat; n++) begin
         if (!bus.xcel_go || bus.xcel_size !== sz || bus.done_val) ok = 1'b0;
         if (n == lat) begin
            bus.xcel_result_val = 1'b1;
            bus.xcel_result = res;
         end
         step();
      end
      bus.xcel_result_val = 1'b0;
      chk("run_stable", ok, 1);
      chk("done_val", bus.done_val, 1);
      chk("done_result", bus.done_result, res);
      chk("done_cycles", bus.done_cycles, 32'(lat));
      chk("total", bus.total, tot);
      chk("jobs_done", bus.jobs_done, jobs);
      chk("drain_go", bus.xcel_go, 0);
      step();
      chk("done_pulse_end", bus.done_val, 0);
      chk("idle_go", bus.xcel_go, 0);
   endtask
   initial begin
      logic ok;
      int   cnt;
      int   dn;
      tbl[0] = '{14'd5,     32'h0000000F, 7,  32'h0000000F, 8'd1};
      tbl[1] = '{14'd0,     32'hFFFFFFFF, 2,  32'h0000000E, 8'd2};
      tbl[2] = '{14'h3FFF,  32'h00000002, 1,  32'h00000010, 8'd3};
      tbl[3] = '{14'd100,   32'h12345678, 10, 32'h12345688, 8'd4};
      bus.job_val = 1'b0;
      bus.job_size = '0;
      bus.xcel_result_val = 1'b0;
      bus.xcel_result = '0;
      step();
      chk("rst_job_rdy", bus.job_rdy, 0);
      chk("rst_go", bus.xcel_go, 0);
      chk("rst_size", bus.xcel_size, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_total", bus.total, 0);
      chk("rst_jobs", bus.jobs_done, 0);
      chk("rst_done_val", bus.done_val, 0);
      rst = 1'b1;
      step();
      chk("rel_job_rdy", bus.job_rdy, 1);
      for (int i = 0; i < 4; i++) begin
         enq(tbl[i].size);
         do_run(tbl[i].size, tbl[i].res, tbl[i].lat, tbl[i].tot, tbl[i].jobs);
      end
      do_reset();
      enq(14'd1);
      do_run(14'd1, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, 8'd1);
      enq(14'd2);
      do_run(14'd2, 32'h2, 4, 32'h1, 8'd2);
      do_reset();
      bus.xcel_result_val = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("full_rdy%0d", i), bus.job_rdy, (i < 4) ? 1 : 0);
         bus.job_val = 1'b1;
         bus.job_size = 14'(11 + i);
         step();
         if (bus.xcel_go) ok = 1'b0;
      end
      bus.job_val = 1'b0;
      bus.xcel_result_val = 1'b0;
      chk("hold_no_dispatch", ok, 1);
      for (int i = 0; i < 4; i++) do_run(14'(11 + i), 32'h1, 1, 32'(i + 1), 8'(i + 1));
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (bus.xcel_go) ok = 1'b0;
         step();
      end
      chk("dropped_job", ok, 1);
      chk("full_busy", bus.busy, 0);
      do_reset();
      enq(14'd3);
      enq(14'd4);
      chk("drain_run", bus.xcel_go, 1);
      bus.xcel_result_val = 1'b1;
      bus.xcel_result = 32'h7;
      step();
      ok = 1'b1;
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.xcel_go) ok = 1'b0;
         dn += int'(bus.done_val);
         step();
      end
      bus.xcel_result_val = 1'b0;
      chk("drain_hold_go", ok, 1);
      chk("drain_one_done", dn, 1);
      chk("drain_busy", bus.busy, 1);
      do_run(14'd4, 32'h10, 3, 32'h17, 8'd2);
      do_reset();
      enq(14'd7);
      enq(14'd9);
      cnt = 0;
      ok = 1'b1;
      while (bus.xcel_go && cnt < 30) begin
         cnt++;
         if (bus.done_val) ok = 1'b0;
         step();
      end
      chk("tmo_go_cycles", cnt, 10);
      chk("tmo_err", bus.err, 1);
      chk("tmo_no_done", ok && !bus.done_val, 1);
      chk("tmo_jobs", bus.jobs_done, 0);
      chk("tmo_total", bus.total, 0);
      chk("tmo_done_cycles", bus.done_cycles, 0);
      do_run(14'd9, 32'h55, 2, 32'h55, 8'd1);
      chk("err_sticky", bus.err, 1);
      enq(14'd20);
      enq(14'd21);
      enq(14'd22);
      chk("mid_run", bus.xcel_go, 1);
      rst = 1'b0;
      step();
      chk("mrst_go", bus.xcel_go, 0);
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_rdy", bus.job_rdy, 0);
      chk("mrst_total", bus.total, 0);
      chk("mrst_jobs", bus.jobs_done, 0);
      chk("mrst_err", bus.err, 0);
      chk("mrst_size", bus.xcel_size, 0);
      chk("mrst_result", bus.done_result, 0);
      chk("mrst_cycles", bus.done_cycles, 0);
      rst = 1'b1;
      step();
      chk("rel2_rdy", bus.job_rdy, 1);
      chk("rel2_go", bus.xcel_go, 0);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (bus.xcel_go || bus.busy) ok = 1'b0;
         step();
      end
      chk("flushed", ok, 1);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
